// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I controller: state encodings,
// datapath mux/ALU codes, RV32I opcodes and the DECODE dispatch function.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEM_ADR = 4'd2,
        ST_MEM_RD  = 4'd3,
        ST_MEM_WB  = 4'd4,
        ST_MEM_WR  = 4'd5,
        ST_EXEC_R  = 4'd6,
        ST_EXEC_I  = 4'd7,
        ST_ALU_WB  = 4'd8,
        ST_BRANCH  = 4'd9,
        ST_JAL     = 4'd10,
        ST_JALR    = 4'd11,
        ST_LINK    = 4'd12,
        ST_TRAP    = 4'd13
    } state_t;

    localparam logic [1:0] ALUSRC_A_PC    = 2'b00;
    localparam logic [1:0] ALUSRC_A_OLDPC = 2'b01;
    localparam logic [1:0] ALUSRC_A_RS1   = 2'b10;

    localparam logic [1:0] ALUSRC_B_RS2   = 2'b00;
    localparam logic [1:0] ALUSRC_B_IMM   = 2'b01;
    localparam logic [1:0] ALUSRC_B_FOUR  = 2'b10;

    localparam logic [1:0] RESULT_ALUOUT  = 2'b00;
    localparam logic [1:0] RESULT_MEM     = 2'b01;
    localparam logic [1:0] RESULT_ALU     = 2'b10;

    localparam logic [1:0] ALUOP_RTYPE    = 2'b00;
    localparam logic [1:0] ALUOP_ADD      = 2'b01;
    localparam logic [1:0] ALUOP_ITYPE    = 2'b10;
    localparam logic [1:0] ALUOP_BRANCH   = 2'b11;

    localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
    localparam logic [6:0] OPCODE_RTYPE   = 7'b0110011;
    localparam logic [6:0] OPCODE_ITYPE   = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI     = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL     = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR    = 7'b1100111;

    // Successor of DECODE; unknown opcodes land in TRAP.
    function automatic state_t decode_target(input logic [6:0] opcode);
        state_t nxt;
        case (opcode)
            OPCODE_LOAD, OPCODE_STORE: nxt = ST_MEM_ADR;
            OPCODE_RTYPE:              nxt = ST_EXEC_R;
            OPCODE_ITYPE, OPCODE_LUI:  nxt = ST_EXEC_I;
            OPCODE_AUIPC:              nxt = ST_ALU_WB;
            OPCODE_BRANCH:             nxt = ST_BRANCH;
            OPCODE_JAL:                nxt = ST_JAL;
            OPCODE_JALR:               nxt = ST_JALR;
            default:                   nxt = ST_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle controller (master)
// and the shared-memory datapath (slave).
interface multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             branch_taken;
    logic             pc_write;
    logic             ir_write;
    logic             adr_src;
    logic             mem_req;
    logic             mem_we;
    logic             reg_we;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       result_src;
    logic             illegal_instr;
    logic             bus_err;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;

    modport master (
        input  opcode, mem_ready, branch_taken,
        output pc_write, ir_write, adr_src, mem_req, mem_we, reg_we,
               alu_src_a, alu_src_b, alu_op, result_src,
               illegal_instr, bus_err, state_o, cycle_cnt, instret_cnt
    );

    modport slave (
        output opcode, mem_ready, branch_taken,
        input  pc_write, ir_write, adr_src, mem_req, mem_we, reg_we,
               alu_src_a, alu_src_b, alu_op, result_src,
               illegal_instr, bus_err, state_o, cycle_cnt, instret_cnt
    );
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts stalled memory-request cycles and flags expiry on the last
// allowed wait cycle. MEM_TIMEOUT = 0 disables expiry.
module multicycle_ctrl_mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic ready,
    input  logic clr,
    output logic expire
);
    localparam int unsigned W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int unsigned LAST   = (MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0;
    localparam logic [W-1:0] LAST_W = W'(LAST);
    localparam logic        TO_EN  = (MEM_TIMEOUT != 0);

    logic [W-1:0] cnt_r;

    // Wait counter: advances only while a request is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr || ready || !req) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + W'(1);
        end
    end

    // A ready in the final wait cycle still completes the transfer.
    assign expire = TO_EN && req && !ready && (cnt_r == LAST_W);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM for the shared instruction/data memory datapath.
// Optional performance counters are compiled in when CTRL_PERF_CNT_EN is defined.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    multicycle_ctrl_if.master bus
);
    state_t     state_r;
    state_t     state_next_s;
    logic       illegal_r;
    logic       bus_err_r;
    logic       set_ill_s;
    logic       set_berr_s;
    logic       req_state_s;
    logic       expire_s;
    logic       pc_write_s;
    logic       ir_write_s;
    logic       adr_src_s;
    logic       mem_req_s;
    logic       mem_we_s;
    logic       reg_we_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic [1:0] result_src_s;

    // Request states come straight from the state register so the timer never loops through the decoder.
    assign req_state_s = (state_r == ST_FETCH) || (state_r == ST_MEM_RD) || (state_r == ST_MEM_WR);

    multicycle_ctrl_mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_state_s),
        .ready  (bus.mem_ready),
        .clr    (state_next_s != state_r),
        .expire (expire_s)
    );

    // State register and sticky trap flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_FETCH;
            illegal_r <= 1'b0;
            bus_err_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            illegal_r <= illegal_r | set_ill_s;
            bus_err_r <= bus_err_r | set_berr_s;
        end
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        state_next_s = state_r;
        set_ill_s    = 1'b0;
        set_berr_s   = 1'b0;
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        adr_src_s    = 1'b0;
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        reg_we_s     = 1'b0;
        alu_src_a_s  = ALUSRC_A_PC;
        alu_src_b_s  = ALUSRC_B_RS2;
        alu_op_s     = ALUOP_ADD;
        result_src_s = RESULT_ALUOUT;
        case (state_r)
            ST_FETCH: begin
                mem_req_s    = 1'b1;
                alu_src_a_s  = ALUSRC_A_PC;
                alu_src_b_s  = ALUSRC_B_FOUR;
                result_src_s = RESULT_ALU;
                if (bus.mem_ready) begin
                    ir_write_s   = 1'b1;
                    pc_write_s   = 1'b1;
                    state_next_s = ST_DECODE;
                end else if (expire_s) begin
                    state_next_s = ST_TRAP;
                    set_berr_s   = 1'b1;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                alu_src_a_s  = ALUSRC_A_OLDPC;
                alu_src_b_s  = ALUSRC_B_IMM;
                state_next_s = decode_target(bus.opcode);
                set_ill_s    = (decode_target(bus.opcode) == ST_TRAP);
            end
            ST_MEM_ADR: begin
                alu_src_a_s  = ALUSRC_A_RS1;
                alu_src_b_s  = ALUSRC_B_IMM;
                if (bus.opcode == OPCODE_LOAD) begin
                    state_next_s = ST_MEM_RD;
                end else begin
                    state_next_s = ST_MEM_WR;
                end
            end
            ST_MEM_RD: begin
                mem_req_s = 1'b1;
                adr_src_s = 1'b1;
                if (bus.mem_ready) begin
                    state_next_s = ST_MEM_WB;
                end else if (expire_s) begin
                    state_next_s = ST_TRAP;
                    set_berr_s   = 1'b1;
                end else begin
                    state_next_s = ST_MEM_RD;
                end
            end
            ST_MEM_WB: begin
                reg_we_s     = 1'b1;
                result_src_s = RESULT_MEM;
                state_next_s = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_req_s = 1'b1;
                mem_we_s  = 1'b1;
                adr_src_s = 1'b1;
                if (bus.mem_ready) begin
                    state_next_s = ST_FETCH;
                end else if (expire_s) begin
                    state_next_s = ST_TRAP;
                    set_berr_s   = 1'b1;
                end else begin
                    state_next_s = ST_MEM_WR;
                end
            end
            ST_EXEC_R: begin
                alu_src_a_s  = ALUSRC_A_RS1;
                alu_src_b_s  = ALUSRC_B_RS2;
                alu_op_s     = ALUOP_RTYPE;
                state_next_s = ST_ALU_WB;
            end
            ST_EXEC_I: begin
                alu_src_a_s  = ALUSRC_A_RS1;
                alu_src_b_s  = ALUSRC_B_IMM;
                alu_op_s     = ALUOP_ITYPE;
                state_next_s = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                reg_we_s     = 1'b1;
                result_src_s = RESULT_ALUOUT;
                state_next_s = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a_s  = ALUSRC_A_RS1;
                alu_src_b_s  = ALUSRC_B_RS2;
                alu_op_s     = ALUOP_BRANCH;
                result_src_s = RESULT_ALUOUT;
                pc_write_s   = bus.branch_taken;
                state_next_s = ST_FETCH;
            end
            ST_JAL: begin
                // PC takes the DECODE target while the ALU forms the link value.
                pc_write_s   = 1'b1;
                result_src_s = RESULT_ALUOUT;
                alu_src_a_s  = ALUSRC_A_OLDPC;
                alu_src_b_s  = ALUSRC_B_FOUR;
                state_next_s = ST_ALU_WB;
            end
            ST_JALR: begin
                alu_src_a_s  = ALUSRC_A_RS1;
                alu_src_b_s  = ALUSRC_B_IMM;
                result_src_s = RESULT_ALU;
                pc_write_s   = 1'b1;
                state_next_s = ST_LINK;
            end
            ST_LINK: begin
                alu_src_a_s  = ALUSRC_A_OLDPC;
                alu_src_b_s  = ALUSRC_B_FOUR;
                state_next_s = ST_ALU_WB;
            end
            ST_TRAP: begin
                state_next_s = ST_TRAP;
            end
            default: begin
                state_next_s = ST_TRAP;
            end
        endcase
    end

    assign bus.pc_write      = pc_write_s;
    assign bus.ir_write      = ir_write_s;
    assign bus.adr_src       = adr_src_s;
    assign bus.mem_req       = mem_req_s;
    assign bus.mem_we        = mem_we_s;
    assign bus.reg_we        = reg_we_s;
    assign bus.alu_src_a     = alu_src_a_s;
    assign bus.alu_src_b     = alu_src_b_s;
    assign bus.alu_op        = alu_op_s;
    assign bus.result_src    = result_src_s;
    assign bus.illegal_instr = illegal_r;
    assign bus.bus_err       = bus_err_r;
    assign bus.state_o       = state_r;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_r;
    logic [CNT_W-1:0] instret_cnt_r;
    logic             retire_s;

    assign retire_s = (state_next_s == ST_FETCH) &&
                      ((state_r == ST_MEM_WB) || (state_r == ST_MEM_WR) ||
                       (state_r == ST_ALU_WB) || (state_r == ST_BRANCH));

    // Performance counters; frozen once trapped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt_r   <= '0;
            instret_cnt_r <= '0;
        end else if (state_r != ST_TRAP) begin
            cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
            if (retire_s) begin
                instret_cnt_r <= instret_cnt_r + CNT_W'(1);
            end else begin
                instret_cnt_r <= instret_cnt_r;
            end
        end else begin
            cycle_cnt_r   <= cycle_cnt_r;
            instret_cnt_r <= instret_cnt_r;
        end
    end

    assign bus.cycle_cnt   = cycle_cnt_r;
    assign bus.instret_cnt = instret_cnt_r;
`else
    assign bus.cycle_cnt   = {CNT_W{1'b0}};
    assign bus.instret_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl (MEM_TIMEOUT = 4).
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_NONE  = 7'b0000000;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    localparam logic [3:0] S_F = 4'd0,  S_D = 4'd1,  S_MA = 4'd2,  S_MR = 4'd3;
    localparam logic [3:0] S_MWB = 4'd4, S_MW = 4'd5, S_XR = 4'd6, S_XI = 4'd7;
    localparam logic [3:0] S_AWB = 4'd8, S_BR = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11;
    localparam logic [3:0] S_LNK = 4'd12, S_TRAP = 4'd13;

    // {adr_src, mem_req, mem_we, reg_we, alu_src_a, alu_src_b, alu_op, result_src}
    localparam logic [11:0] W_F    = 12'b0100_00_10_01_10;
    localparam logic [11:0] W_D    = 12'b0000_01_01_01_00;
    localparam logic [11:0] W_MA   = 12'b0000_10_01_01_00;
    localparam logic [11:0] W_MR   = 12'b1100_00_00_01_00;
    localparam logic [11:0] W_MWB  = 12'b0001_00_00_01_01;
    localparam logic [11:0] W_MW   = 12'b1110_00_00_01_00;
    localparam logic [11:0] W_XR   = 12'b0000_10_00_00_00;
    localparam logic [11:0] W_XI   = 12'b0000_10_01_10_00;
    localparam logic [11:0] W_AWB  = 12'b0001_00_00_01_00;
    localparam logic [11:0] W_BR   = 12'b0000_10_00_11_00;
    localparam logic [11:0] W_JAL  = 12'b0000_01_10_01_00;
    localparam logic [11:0] W_JALR = 12'b0000_10_01_01_10;
    localparam logic [11:0] W_LNK  = 12'b0000_01_10_01_00;
    localparam logic [11:0] W_TRAP = 12'b0000_00_00_01_00;

`ifdef CTRL_PERF_CNT_EN
    localparam int EXP_CYC = 12, EXP_RET = 3, EXP_CYC_TRAP = 4;
`else
    localparam int EXP_CYC = 0, EXP_RET = 0, EXP_CYC_TRAP = 0;
`endif

    typedef struct {
        logic [6:0]  opc;
        logic        rdy;
        logic        bt;
        logic [3:0]  st;
        logic        pw;
        logic        iw;
        logic [11:0] w;
        logic        ill;
    } vec_t;

    localparam int NV = 43;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;
    vec_t vecs [NV];

    multicycle_ctrl_if #(.CNT_W(32)) bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [6:0] opc, input logic rdy, input logic bt,
                                input logic [3:0] st, input logic pw, input logic iw,
                                input logic [11:0] w, input logic ill);
        vec_t v;
        v.opc = opc; v.rdy = rdy; v.bt = bt; v.st = st;
        v.pw = pw; v.iw = iw; v.w = w; v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [13:0] ctrl_word();
        return {bus.pc_write, bus.ir_write, bus.adr_src, bus.mem_req, bus.mem_we, bus.reg_we,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src};
    endfunction

    initial begin
        n_total = 0;
        n_pass  = 0;
        // add, sw, jal (perf window), then lw with 3 waits, beq nt/t, jalr, auipc, lui, fetch wait, illegal
        vecs[0]  = mk(OP_NONE, 1'b1, 1'b0, S_F,    1'b1, 1'b1, W_F,    1'b0);
        vecs[1]  = mk(OP_R,    1'b1, 1'b0, S_D,    1'b0, 1'b0, W_D,    1'b0);
        vecs[2]  = mk(OP_R,    1'b1, 1'b0, S_XR,   1'b0, 1'b0, W_XR,   1'b0);
        vecs[3]  = mk(OP_R,    1'b1, 1'b0, S_AWB,  1'b0, 1'b0, W_AWB,  1'b0);
        vecs[4]  = mk(OP_NONE, 1'b1, 1'b0, S_F,    1'b1, 1'b1, W_F,    1'b0);
        vecs[5]  = mk(OP_S,    1'b1, 1'b0, S_D,    1'b0, 1'b0, W_D,    1'b0);
        vecs[6]  = mk(OP_S,    1'b0, 1'b0, S_MA,   1'b0, 1'b0, W_MA,   1'b0);
        vecs[7]  = mk(OP_S,    1'b1, 1'b0, S_MW,   1'b0, 1'b0, W_MW,   1'b0);
        vecs[8]  = mk(OP_NONE, 1'b1, 1'b0, S_F,    1'b1, 1'b1, W_F,    1'b0);
        vecs[9]  = mk(OP_JAL,  1'b1, 1'b0, S_D,    1'b0, 1'b0, W_D,    1'b0);
        vecs[10] = mk(OP_JAL,  1'b1, 1'b0, S_JAL,  1'b1, 1'b0, W_JAL,  1'b0);
        vecs[11] = mk(OP_JAL,  1'b1, 1'b0, S_AWB,  1'b0, 1'b0, W_AWB,  1'b0);
        vecs[12] = mk(OP_NONE, 1'b1, 1'b0, S_F,    1'b1, 1'b1, W_F,    1'b0);
        vecs[13] = mk(OP_LOAD, 1'b1, 1'b0, S_D,    1'b0, 1'b0, W_D,    1'b0);
        vecs[14] = mk(OP_LOAD, 1'b1, 1'b0, S_MA,   1'b0, 1'b0, W_MA,   1'b0);
        vecs[15] = mk(OP_LOAD, 1'b0, 1'b0, S_MR,   1'b0, 1'b0, W_MR,   1'b0);
        vecs[16] = mk(OP_LOAD, 1'b0, 1'b0, S_MR,   1'b0, 1'b0, W_MR,   1'b0);
        vecs[17] = mk(OP_LOAD, 1'b0, 1'b0, S_MR,   1'b0, 1'b0, W_MR,   1'b0);
        vecs[18] = mk(OP_LOAD, 1'b1, 1'b0, S_MR,   1'b0, 1'b0, W_MR,   1'b0);
        vecs[19] = mk(OP_LOAD, 1'b0, 1'b0, S_MWB,  1'b0, 1'b0, W_MWB,  1'b0);
        vecs[20] = mk(OP_NONE, 1'b1, 1'b0, S_F,    1'b1, 1'b1, W_F,    1'b0);
        vecs[21] = mk(OP_B,    1'b1, 1'b0, S_D,    1'b0, 1'b0, W_D,    1'b0);
        vecs[22] = mk(OP_B,    1'b1, 1'b0, S_BR,   1'b0, 1'b0, W_BR,   1'b0);
        vecs[23] = mk(OP_NONE, 1'b1, 1'b1, S_F,    1'b1, 1'b1, W_F,    1'b0);
        vecs[24] = mk(OP_B,    1'b1, 1'b1, S_D,    1'b0, 1'b0, W_D,    1'b0);
        vecs[25] = mk(OP_B,    1'b1, 1'b1, S_BR,   1'b1, 1'b0, W_BR,   1'b0);
        vecs[26] = mk(OP_NONE, 1'b1, 1'b0, S_F,    1'b1, 1'b1, W_F,    1'b0);
        vecs[27] = mk(OP_JALR, 1'b1, 1'b0, S_D,    1'b0, 1'b0, W_D,    1'b0);
        vecs[28] = mk(OP_JALR, 1'b1, 1'b0, S_JALR, 1'b1, 1'b0, W_JALR, 1'b0);
        vecs[29] = mk(OP_JALR, 1'b1, 1'b0, S_LNK,  1'b0, 1'b0, W_LNK,  1'b0);
        vecs[30] = mk(OP_JALR, 1'b1, 1'b0, S_AWB,  1'b0, 1'b0, W_AWB,  1'b0);
        vecs[31] = mk(OP_NONE, 1'b1, 1'b0, S_F,    1'b1, 1'b1, W_F,    1'b0);
        vecs[32] = mk(OP_AUIPC,1'b1, 1'b0, S_D,    1'b0, 1'b0, W_D,    1'b0);
        vecs[33] = mk(OP_AUIPC,1'b1, 1'b0, S_AWB,  1'b0, 1'b0, W_AWB,  1'b0);
        vecs[34] = mk(OP_NONE, 1'b1, 1'b0, S_F,    1'b1, 1'b1, W_F,    1'b0);
        vecs[35] = mk(OP_LUI,  1'b1, 1'b0, S_D,    1'b0, 1'b0, W_D,    1'b0);
        vecs[36] = mk(OP_LUI,  1'b1, 1'b0, S_XI,   1'b0, 1'b0, W_XI,   1'b0);
        vecs[37] = mk(OP_LUI,  1'b1, 1'b0, S_AWB,  1'b0, 1'b0, W_AWB,  1'b0);
        vecs[38] = mk(OP_NONE, 1'b0, 1'b0, S_F,    1'b0, 1'b0, W_F,    1'b0);
        vecs[39] = mk(OP_NONE, 1'b1, 1'b0, S_F,    1'b1, 1'b1, W_F,    1'b0);
        vecs[40] = mk(OP_BAD,  1'b1, 1'b0, S_D,    1'b0, 1'b0, W_D,    1'b0);
        vecs[41] = mk(OP_BAD,  1'b1, 1'b0, S_TRAP, 1'b0, 1'b0, W_TRAP, 1'b1);
        vecs[42] = mk(OP_BAD,  1'b0, 1'b0, S_TRAP, 1'b0, 1'b0, W_TRAP, 1'b1);

        rst_n            = 1'b0;
        bus.opcode       = OP_NONE;
        bus.mem_ready    = 1'b0;
        bus.branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state",   32'(bus.state_o), 32'(S_F));
        chk("reset_illegal", 32'(bus.illegal_instr), 32'd0);
        chk("reset_bus_err", 32'(bus.bus_err), 32'd0);
        chk("reset_cycle",   bus.cycle_cnt, 32'd0);
        chk("reset_instret", bus.instret_cnt, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            bus.opcode       = vecs[i].opc;
            bus.mem_ready    = vecs[i].rdy;
            bus.branch_taken = vecs[i].bt;
            #1;
            chk($sformatf("v%0d_state", i), 32'(bus.state_o), 32'(vecs[i].st));
            chk($sformatf("v%0d_ctrl", i), 32'(ctrl_word()), 32'({vecs[i].pw, vecs[i].iw, vecs[i].w}));
            chk($sformatf("v%0d_illegal", i), 32'(bus.illegal_instr), 32'(vecs[i].ill));
            chk($sformatf("v%0d_bus_err", i), 32'(bus.bus_err), 32'd0);
            @(negedge clk);
            if (i == 11) begin
                chk("perf_cycle",   bus.cycle_cnt, 32'(EXP_CYC));
                chk("perf_instret", bus.instret_cnt, 32'(EXP_RET));
            end
        end

        // One-edge reset out of TRAP clears the sticky flags.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst2_state",   32'(bus.state_o), 32'(S_F));
        chk("rst2_illegal", 32'(bus.illegal_instr), 32'd0);
        chk("rst2_bus_err", 32'(bus.bus_err), 32'd0);
        chk("rst2_cycle",   bus.cycle_cnt, 32'd0);

        // Fetch never acknowledged: four request cycles, then TRAP with bus_err.
        bus.mem_ready = 1'b0;
        bus.opcode    = OP_NONE;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("to%0d_state", k), 32'(bus.state_o), 32'(S_F));
            chk($sformatf("to%0d_req", k), 32'(bus.mem_req), 32'd1);
            chk($sformatf("to%0d_bus_err", k), 32'(bus.bus_err), 32'd0);
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("trap%0d_state", k), 32'(bus.state_o), 32'(S_TRAP));
            chk($sformatf("trap%0d_bus_err", k), 32'(bus.bus_err), 32'd1);
            chk($sformatf("trap%0d_illegal", k), 32'(bus.illegal_instr), 32'd0);
            chk($sformatf("trap%0d_req", k), 32'(bus.mem_req), 32'd0);
            chk($sformatf("trap%0d_cycle", k), bus.cycle_cnt, 32'(EXP_CYC_TRAP));
            bus.mem_ready = 1'b1;
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle RV32I control FSM. It replaces the single-cycle combinational opcode decoder for the shared-memory datapath. It sequences fetch, decode, execute, memory and writeback over several cycles, using a req/ready handshake with the unified instruction/data memory. It adds a memory-wait timeout and a sticky trap state for illegal opcodes and bus errors. It drives the existing ALU decoder through alu_op.

Parameters:
MEM_TIMEOUT, 16, max wait cycles per memory request before bus error; 0 = no timeout
CNT_W, 32, width of optional performance counters

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
opcode  in  7  instr[6:0] from IR (valid from DECODE onward)
mem_ready  in  1  memory completes current request this cycle
branch_taken  in  1  branch comparison result from ALU/comparator
pc_write  out  1  PC <= selected result
ir_write  out  1  IR <= memory read data
adr_src  out  1  memory address: 0 = PC, 1 = ALUOut
mem_req  out  1  memory request valid
mem_we  out  1  request is a write
reg_we  out  1  register file write
alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1
alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
alu_op  out  2  00 = R-type, 10 = I-type, 01 = add, 11 = branch
result_src  out  2  00 = ALUOut, 01 = mem data, 10 = ALU result
illegal_instr  out  1  sticky: unknown opcode trapped
bus_err  out  1  sticky: memory timeout trapped
state_o  out  4  current state, debug
cycle_cnt  out  CNT_W  cycle counter (optional)
instret_cnt  out  CNT_W  retired instructions (optional)

Behaviour:
- Reset (rst_n = 0 at a clk edge): state <= FETCH, wait counter <= 0, illegal_instr = bus_err = 0. This applies mid-operation, including an outstanding request, which is dropped.
- Outputs are decoded from state. Defaults are all 0 with alu_op = 01. Only pc_write and ir_write also depend on inputs.
- FETCH: mem_req = 1, adr_src = 0, a = 00, b = 10, alu_op = 01, result_src = 10. When mem_ready = 1: ir_write = 1, pc_write = 1 (PC += 4), next state DECODE. Otherwise hold.
- DECODE: a = 01, b = 01, alu_op = 01, so ALUOut <= oldPC + imm.
  - LOAD or S -> MEM_ADR; R -> EXEC_R; I_ARITH or LUI -> EXEC_I; AUIPC -> ALU_WB.
  - B -> BRANCH; JAL -> JAL; JALR -> JALR.
  - Any other opcode -> TRAP with illegal_instr <= 1.
- MEM_ADR: a = 10, b = 01, alu_op = 01. Next is MEM_RD if opcode = LOAD, else MEM_WR.
- MEM_RD: mem_req = 1, adr_src = 1. On mem_ready -> MEM_WB.
- MEM_WB: reg_we = 1, result_src = 01 -> FETCH.
- MEM_WR: mem_req = 1, mem_we = 1, adr_src = 1. On mem_ready -> FETCH.
- EXEC_R: a = 10, b = 00, alu_op = 00 -> ALU_WB.
- EXEC_I: a = 10, b = 01, alu_op = 10 -> ALU_WB.
- ALU_WB: reg_we = 1, result_src = 00 -> FETCH.
- BRANCH: a = 10, b = 00, alu_op = 11, result_src = 00, pc_write = branch_taken -> FETCH.
- JAL: pc_write = 1, result_src = 00 (target from DECODE). Same cycle a = 01, b = 10, alu_op = 01, so ALUOut <= oldPC + 4. Next ALU_WB.
- JALR: a = 10, b = 01, alu_op = 01, result_src = 10, pc_write = 1 -> LINK.
- LINK: a = 01, b = 10, alu_op = 01 -> ALU_WB.
- TRAP: all enables 0, mem_req = 0. Stays in TRAP until reset.
- Handshake:
  - mem_req, adr_src and mem_we are held stable until the cycle mem_ready = 1.
  - mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.
  - The transfer completes in the same cycle ready is seen; a zero-wait memory gives FETCH = 1 cycle.
- Timeout:
  - The wait counter increments each cycle mem_req = 1 and mem_ready = 0, and clears on completion or state change.
  - If MEM_TIMEOUT != 0 and the counter = MEM_TIMEOUT - 1 with mem_ready = 0, next state is TRAP and bus_err <= 1.
  - mem_ready = 1 in that same cycle wins; no error is raised.
- Latency, zero-wait memory, in cycles: R/I/LUI/AUIPC 4 (AUIPC 3), load 5, store 4, branch 3, JAL 4, JALR 5.

Optional Feature:
CTRL_PERF_CNT_EN
- Defined: cycle_cnt increments every cycle not in reset. instret_cnt increments on each transition into FETCH from MEM_WB, MEM_WR, ALU_WB or BRANCH. Both counters wrap modulo 2^CNT_W, reset to 0, and freeze in TRAP.
- Undefined: counter logic is not compiled; ports remain and are driven 0.

Decomposition:
- Add to defines.v (shared constants):
  - state encodings ST_FETCH..ST_TRAP (4-bit);
  - ALUSRC_A_*, ALUSRC_B_*, RESULT_* and ALUOP_* codes.
- OPCODE_* constants are reused.
- One natural sub-module: mem_wait_timer (counter, clear, MEM_TIMEOUT compare, expire flag).

Test Plan:
- add x3,x1,x2 (opcode 0110011), mem_ready = 1 always -> states FETCH, DECODE, EXEC_R, ALU_WB; reg_we = 1 on cycle 4 only; alu_op = 00 in EXEC_R.
- lw with mem_ready low for 3 cycles in MEM_RD -> mem_req, adr_src = 1 held 4 cycles; MEM_WB with result_src = 01 next; no bus_err.
- MEM_TIMEOUT = 4, FETCH with mem_ready = 0 forever -> TRAP after 4 request cycles; bus_err = 1; mem_req = 0 thereafter.
- beq with branch_taken = 0, then = 1 -> pc_write = 0, then 1, in BRANCH; both return to FETCH after 3 cycles.
- opcode 7'b1111111 -> DECODE then TRAP; illegal_instr = 1. Assert rst_n = 0 for one edge -> FETCH, flags cleared.
- CTRL_PERF_CNT_EN defined: sequence add, sw, jal with zero-wait memory -> instret_cnt = 3, cycle_cnt = 12.
